// File: rtl/cpu_types_pkg.sv
// Shared types for the memory side of the cache/controller protocol.
//   word_t       : 32-bit data/address word
//   ramstate_t   : status reported by the RAM model each cycle
//   CPUS_DEFAULT : default number of cores seen by the arbiter
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam int CPUS_DEFAULT = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker.
//   req   : one request bit per core
//   ptr   : core index that has highest priority this round
//   grant : one-hot winner (all zero when no request)
//   idx   : binary index of the winner
//   any   : at least one request present
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int cand;

  // Scan from ptr upward, wrapping; the first requester seen wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(ptr) + i) % N;
      if (!any && req[cand[IW-1:0]]) begin
        any = 1'b1;
        idx = cand[IW-1:0];
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/memory_arbiter.sv
// Memory-side responder: arbitrates instruction and data requests from all
// cores onto a single-ported RAM and returns per-requester wait/load.
//   CLK, nRST            : clock, async active-low reset
//   iREN/dREN/dWEN       : per-core request strobes (write wins over read)
//   iaddr/daddr/dstore   : per-core addresses and write data (not latched)
//   iwait/dwait          : per-core wait, low only in the completing cycle
//   iload/dload          : ramload broadcast to every core
//   ramREN/ramWEN/ramaddr/ramstore : RAM side strobes, address, write data
//   ramload/ramstate     : RAM read data and status
//
// state  | meaning
// IDLE   | no grant; strobes low; pick a winner if anyone requests
// ACTIVE | owner's live request drives the RAM until ACCESS/ERROR/withdraw
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = CPUS_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  word_t [CPUS-1:0]     iaddr,
  input  word_t [CPUS-1:0]     daddr,
  input  word_t [CPUS-1:0]     dstore,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS-1:0]      dwait,
  output word_t [CPUS-1:0]     iload,
  output word_t [CPUS-1:0]     dload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output word_t                ramaddr,
  output word_t                ramstore,
  input  word_t                ramload,
  input  ramstate_t            ramstate
);

  localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;

  typedef enum logic {IDLE, ACTIVE} arb_state_t;

  arb_state_t      state, state_nxt;
  logic [IW-1:0]   owner_core, owner_core_nxt;
  logic            owner_isd, owner_isd_nxt;
  logic [IW-1:0]   rr, rr_nxt, rr_inc;
  logic [CPUS-1:0] core_req, win_grant;
  logic [IW-1:0]   win_idx;
  logic            win_any;
  logic            own_iren, own_dren, own_dwen, own_live;

  assign core_req = iREN | dREN | dWEN;

  rr_arbiter #(.N(CPUS), .IW(IW)) u_rr_arbiter (
    .req   (core_req),
    .ptr   (rr),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  // Owner signals are read live every cycle; dropping them aborts the grant.
  assign own_iren = iREN[owner_core];
  assign own_dren = dREN[owner_core];
  assign own_dwen = dWEN[owner_core];
  assign own_live = owner_isd ? (own_dren | own_dwen) : own_iren;

  assign rr_inc = (owner_core == IW'(CPUS - 1)) ? '0 : owner_core + IW'(1);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      owner_core <= '0;
      owner_isd  <= 1'b0;
      rr         <= '0;
    end else begin
      state      <= state_nxt;
      owner_core <= owner_core_nxt;
      owner_isd  <= owner_isd_nxt;
      rr         <= rr_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_core_nxt = owner_core;
    owner_isd_nxt  = owner_isd;
    rr_nxt         = rr;
    case (state)
      IDLE: begin
        if (win_any) begin
          state_nxt      = ACTIVE;
          owner_core_nxt = win_idx;
          // Within the winning core a data request beats an instruction fetch.
          owner_isd_nxt  = |(win_grant & (dREN | dWEN));
        end
      end
      ACTIVE: begin
        if (!own_live) begin
          state_nxt = IDLE;
        end else if (ramstate == ACCESS) begin
          state_nxt = IDLE;
          rr_nxt    = rr_inc;
        end else if (ramstate == ERROR) begin
          // Pointer untouched so the same requester is retried first.
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    if (state == ACTIVE && own_live) begin
      if (owner_isd) begin
        ramaddr = daddr[owner_core];
        if (own_dwen) begin
          ramWEN   = 1'b1;
          ramstore = dstore[owner_core];
        end else begin
          ramREN = 1'b1;
        end
      end else begin
        ramREN  = 1'b1;
        ramaddr = iaddr[owner_core];
      end
      if (ramstate == ACCESS) begin
        if (owner_isd) dwait[owner_core] = 1'b0;
        else           iwait[owner_core] = 1'b0;
      end
    end
  end

  assign iload = {CPUS{ramload}};
  assign dload = {CPUS{ramload}};

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int N = 2;
  localparam word_t LOADV = 32'hDEADBEEF;

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic [N-1:0]      iREN, dREN, dWEN;
  logic [N-1:0][31:0] iaddr, daddr, dstore;
  logic [N-1:0]      iwait, dwait;
  logic [N-1:0][31:0] iload, dload;
  logic              ramREN, ramWEN;
  word_t             ramaddr, ramstore, ramload;
  ramstate_t         ramstate;

  always #5 CLK = ~CLK;

  memory_arbiter #(.CPUS(N)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  typedef struct {
    string     name;
    logic [1:0] ir, dr, dw;
    ramstate_t rs;
    logic [1:0] eiw, edw;
    logic      eren, ewen;
    word_t     ea, es;
  } vec_t;

  int checks = 0;
  int failures = 0;
  vec_t tbl[$];
  vec_t v;

  function automatic vec_t mk(string n, logic [1:0] ir, logic [1:0] dr, logic [1:0] dw,
                              ramstate_t rs, logic [1:0] eiw, logic [1:0] edw,
                              logic eren, logic ewen, word_t ea, word_t es);
    vec_t r;
    r.name = n; r.ir = ir; r.dr = dr; r.dw = dw; r.rs = rs;
    r.eiw = eiw; r.edw = edw; r.eren = eren; r.ewen = ewen; r.ea = ea; r.es = es;
    return r;
  endfunction

  // Requests present but arbiter idle: everything parked.
  function automatic vec_t idle(string n, logic [1:0] ir, logic [1:0] dr, logic [1:0] dw,
                                ramstate_t rs);
    return mk(n, ir, dr, dw, rs, 2'b11, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0);
  endfunction

  task automatic chk(string nm, string what, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s/%s: got %h expected %h", nm, what, act, exp);
    end
  endtask

  task automatic drive(vec_t r);
    iREN = r.ir; dREN = r.dr; dWEN = r.dw; ramstate = r.rs;
  endtask

  task automatic check(vec_t r);
    chk(r.name, "waits{i,d}", 64'({iwait, dwait}), 64'({r.eiw, r.edw}));
    chk(r.name, "strobes{ren,wen}", 64'({ramREN, ramWEN}), 64'({r.eren, r.ewen}));
    chk(r.name, "ramaddr", 64'(ramaddr), 64'(r.ea));
    chk(r.name, "ramstore", 64'(ramstore), 64'(r.es));
    if ({r.eiw, r.edw} != 4'hF) begin
      chk(r.name, "iload", 64'(iload), {LOADV, LOADV});
      chk(r.name, "dload", 64'(dload), {LOADV, LOADV});
    end
  endtask

  task automatic apply(vec_t r);
    @(negedge CLK);
    drive(r);
    #1;
    check(r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iREN = '0; dREN = '0; dWEN = '0; ramstate = FREE;
    iaddr[0] = 32'h40;  iaddr[1] = 32'h44;
    daddr[0] = 32'h80;  daddr[1] = 32'h90;
    dstore[0] = 32'h1234; dstore[1] = 32'h5678;
    ramload = LOADV;

    // Single I read on core0 with two BUSY cycles before ACCESS.
    tbl.push_back(idle("i0_idle", 2'b01, 2'b00, 2'b00, FREE));
    tbl.push_back(mk("i0_busy1", 2'b01, 2'b00, 2'b00, BUSY, 2'b11, 2'b11, 1, 0, 32'h40, 0));
    tbl.push_back(mk("i0_busy2", 2'b01, 2'b00, 2'b00, BUSY, 2'b11, 2'b11, 1, 0, 32'h40, 0));
    tbl.push_back(mk("i0_access", 2'b01, 2'b00, 2'b00, ACCESS, 2'b10, 2'b11, 1, 0, 32'h40, 0));
    tbl.push_back(idle("i0_after", 2'b00, 2'b00, 2'b00, FREE));
    // Core0 I read and D write together: write first, then the fetch.
    tbl.push_back(idle("idw_idle", 2'b01, 2'b00, 2'b01, FREE));
    tbl.push_back(mk("idw_write", 2'b01, 2'b00, 2'b01, ACCESS, 2'b11, 2'b10, 0, 1, 32'h80, 32'h1234));
    tbl.push_back(idle("idw_iidle", 2'b01, 2'b00, 2'b00, FREE));
    tbl.push_back(mk("idw_iread", 2'b01, 2'b00, 2'b00, ACCESS, 2'b10, 2'b11, 1, 0, 32'h40, 0));
    // Core1 read alone brings the pointer back to core0.
    tbl.push_back(idle("d1_idle", 2'b00, 2'b10, 2'b00, FREE));
    tbl.push_back(mk("d1_read", 2'b00, 2'b10, 2'b00, ACCESS, 2'b11, 2'b01, 1, 0, 32'h90, 0));
    // Both cores read continuously: strict alternation starting at core0.
    for (int k = 0; k < 2; k++) begin
      tbl.push_back(idle("rot_idle_a", 2'b00, 2'b11, 2'b00, FREE));
      tbl.push_back(mk("rot_c0", 2'b00, 2'b11, 2'b00, ACCESS, 2'b11, 2'b10, 1, 0, 32'h80, 0));
      tbl.push_back(idle("rot_idle_b", 2'b00, 2'b11, 2'b00, FREE));
      tbl.push_back(mk("rot_c1", 2'b00, 2'b11, 2'b00, ACCESS, 2'b11, 2'b01, 1, 0, 32'h90, 0));
    end

    #2;
    v = idle("reset", 2'b00, 2'b00, 2'b00, FREE);
    check(v);
    @(negedge CLK);
    nRST = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // ERROR during core1 write: no completion, retried, then completes.
    apply(idle("err_idle", 2'b00, 2'b00, 2'b10, FREE));
    apply(mk("err_error", 2'b00, 2'b00, 2'b10, ERROR, 2'b11, 2'b11, 0, 1, 32'h90, 32'h5678));
    apply(idle("err_retry_idle", 2'b00, 2'b00, 2'b10, FREE));
    apply(mk("err_access", 2'b00, 2'b00, 2'b10, ACCESS, 2'b11, 2'b01, 0, 1, 32'h90, 32'h5678));

    // Core0 withdraws while BUSY; pointer must stay on core0.
    apply(idle("ab_idle", 2'b00, 2'b01, 2'b00, FREE));
    apply(mk("ab_busy", 2'b00, 2'b01, 2'b00, BUSY, 2'b11, 2'b11, 1, 0, 32'h80, 0));
    apply(idle("ab_drop", 2'b00, 2'b00, 2'b00, BUSY));
    apply(idle("ab_rr_idle", 2'b00, 2'b11, 2'b00, FREE));
    apply(mk("ab_rr_c0", 2'b00, 2'b11, 2'b00, ACCESS, 2'b11, 2'b10, 1, 0, 32'h80, 0));

    // Reset while core1 owns the RAM; pointer returns to core0 afterwards.
    apply(idle("rst_idle", 2'b11, 2'b00, 2'b00, FREE));
    apply(mk("rst_busy", 2'b11, 2'b00, 2'b00, BUSY, 2'b11, 2'b11, 1, 0, 32'h44, 0));
    nRST = 1'b0;
    #1;
    check(idle("rst_mid", 2'b11, 2'b00, 2'b00, BUSY));
    @(negedge CLK);
    nRST = 1'b1;
    v = idle("rst_rel", 2'b11, 2'b00, 2'b00, FREE);
    drive(v);
    #1;
    check(v);
    apply(mk("rst_c0", 2'b11, 2'b00, 2'b00, ACCESS, 2'b10, 2'b11, 1, 0, 32'h40, 0));
    apply(idle("end_idle", 2'b00, 2'b00, 2'b00, FREE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
